kiwi_led_sequencer: RTL
=======================

# kiwi_led_sequencer

Pattern generator that drives the eight on-board active-low LEDs of the Kiwi board. It generates its own step tick from the 50 MHz clock and steps through one of four selectable patterns: off, blink-all, chase and bounce. An optional PWM stage sets overall brightness. It sits directly upstream of the LED pins and replaces single-LED blink logic as the board's LED output stage.

## Interface
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- STEP_HZ, 4: pattern step rate in Hz. DIV = CLK_HZ/STEP_HZ (integer division); DIV ≥ 2 is required.
- CLK_50  in  1  system clock; the only clock.
- RST  in  1  reset, synchronous, active-high.
- MODE  in  2  pattern select: 00 OFF, 01 BLINK, 10 CHASE, 11 BOUNCE.
- BRIGHT  in  8  PWM duty, lit fraction BRIGHT/256. Used only when LED_SEQ_PWM_EN is defined.
- PAUSE  in  1  freezes the prescaler and the pattern while high.
- STEP_TICK  out  1  one-cycle pulse, high in the first cycle a new pattern step is visible.
- LED  out  8  LED drive, active-low: 1 = off.

## Operation
- Internal pattern pat[7:0] is active-high (1 = lit). LED = ~(pat & {8{pwm_on}}).
- Prescaler: cnt, width $clog2(DIV), counts 0..DIV-1 and wraps to 0. A step occurs at a clock edge where cnt == DIV-1, PAUSE = 0 and there is no mode change.
- PAUSE = 1: cnt, pat and dir hold, and no step occurs. On release, counting resumes from the held cnt.
- Mode change: detected when MODE != mode_q (the registered MODE). On that edge:
  - mode_q <= MODE, cnt <= 0, dir <= up, STEP_TICK <= 0.
  - pat <= initial value: OFF 0x00, BLINK 0xFF, CHASE 0x01, BOUNCE 0x01.
  - Mode change takes priority over a coincident step and over PAUSE.
- Behaviour on each step:
  - OFF: pat stays 0x00.
  - BLINK: pat toggles 0xFF ↔ 0x00.
  - CHASE: pat rotates left 1 bit; 0x80 → 0x01.
  - BOUNCE: dir up shifts left; on 0x80, reverse (next 0x40, dir down). dir down shifts right; on 0x01, reverse (next 0x02, dir up). The period is 14 steps.
- STEP_TICK is registered: 1 for exactly the cycle after a step edge, otherwise 0.
- Reset (any cycle, including mid-pattern or mid-PAUSE): cnt 0, pat 0x00, mode_q 00, dir up, pwm_cnt 0, STEP_TICK 0, hence LED 0xFF. If MODE != 00 when RST falls, the first cycle out of reset is a mode change that loads the initial pattern.

## Timing
- All state is updated on posedge CLK_50. LED is a combinational function of registered state, with no added latency.
- Mode-change latency: the new initial pattern is on LED one cycle after MODE changes. The first step follows DIV cycles later.
- Steady-state step period: exactly DIV cycles (12_500_000 at the default parameters). STEP_TICK is aligned with the first cycle of each new pattern.
- PWM: pwm_cnt is 8 bits, free-running, +1 per cycle, 255 → 0. pwm_on = (pwm_cnt < BRIGHT).
  - BRIGHT = 0: always dark.
  - BRIGHT = 255: lit 255 of every 256 cycles.
  - PWM frequency is about 195 kHz. pwm_cnt is not affected by MODE or PAUSE.

## Configuration
- LED_SEQ_PWM_EN defined: pwm_cnt and the comparator are built, and brightness follows BRIGHT.
- LED_SEQ_PWM_EN undefined: pwm_on is tied to 1, BRIGHT is unused and no PWM logic is synthesized.

## Structure
- Shared package kiwi_led_pkg holds:
  - mode constants MODE_OFF / MODE_BLINK / MODE_CHASE / MODE_BOUNCE;
  - the initial pattern constants;
  - LED_ALL_OFF = 8'hFF.
- One sub-module, kiwi_tick_prescaler, provides the prescaler:
  - parameters: DIV;
  - inputs: CLK_50, RST, en, clr;
  - output: tick.
- The pattern FSM, PWM and output stage live in the top module.

## Test plan
All scenarios use CLK_HZ = 16, STEP_HZ = 4, giving DIV = 4. Scenarios 1–5 run with LED_SEQ_PWM_EN undefined.
1. RST high for 3 cycles with MODE = 10 → LED = 0xFF and STEP_TICK = 0 throughout. One cycle after RST falls, LED = 0xFE.
2. CHASE free-running → STEP_TICK every 4 cycles. LED steps FE, FD, FB, F7, EF, DF, BF, 7F, then FE again.
3. BOUNCE → LED after 7 steps = 0x7F, after 8 steps = 0xBF, after 14 steps = 0xFE. dir reverses at both ends with no repeated value.
4. PAUSE high for 10 cycles mid-CHASE → no STEP_TICK and LED constant. After release, the next STEP_TICK comes DIV − cnt_held cycles later.
5. MODE 10 → 01 on the same edge as cnt == 3 → no STEP_TICK, LED = 0x00 (pat 0xFF) next cycle. The next STEP_TICK arrives 4 cycles later with LED = 0xFF.
6. LED_SEQ_PWM_EN defined, MODE = 01, no step within the window:
   - BRIGHT = 64 → over 256 cycles, LED = 0x00 for exactly 64 cycles (pwm_cnt 0..63), 0xFF otherwise.
   - BRIGHT = 0 → LED = 0xFF for all 256 cycles.

Source files
------------

// File: rtl/kiwi_led_pkg.sv
// Shared constants for the Kiwi LED sequencer: mode codes, initial patterns,
// bounce direction type. Optional PWM stage is enabled with LED_SEQ_PWM_EN.
package kiwi_led_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_CHASE  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic [7:0] PAT_INIT_OFF    = 8'h00;
  localparam logic [7:0] PAT_INIT_BLINK  = 8'hFF;
  localparam logic [7:0] PAT_INIT_CHASE  = 8'h01;
  localparam logic [7:0] PAT_INIT_BOUNCE = 8'h01;

  localparam logic [7:0] LED_ALL_OFF = 8'hFF;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic logic [7:0] init_pat(input logic [1:0] mode);
    case (mode)
      MODE_BLINK:  init_pat = PAT_INIT_BLINK;
      MODE_CHASE:  init_pat = PAT_INIT_CHASE;
      MODE_BOUNCE: init_pat = PAT_INIT_BOUNCE;
      default:     init_pat = PAT_INIT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/kiwi_tick_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled and flags the edge that
// wraps the count. clr restarts the count and suppresses that edge's tick.
module kiwi_tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic CLK_50,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/kiwi_led_sequencer.sv
// Kiwi board LED output stage: steps off/blink/chase/bounce patterns on the
// eight active-low LEDs. Define LED_SEQ_PWM_EN to add BRIGHT-controlled PWM.
//
// state    | meaning
// DIR_UP   | bounce pattern moving toward bit 7 (also the idle value)
// DIR_DOWN | bounce pattern moving toward bit 0
module kiwi_led_sequencer
  import kiwi_led_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 4
) (
  input  logic       CLK_50,
  input  logic       RST,
  input  logic [1:0] MODE,
  input  logic [7:0] BRIGHT,
  input  logic       PAUSE,
  output logic       STEP_TICK,
  output logic [7:0] LED
);

  localparam int DIV = CLK_HZ / STEP_HZ;

  logic [1:0] mode_q;
  logic [7:0] pat;
  dir_t       dir;
  logic       mode_chg;
  logic       step;
  logic       pwm_on;

  assign mode_chg = (MODE != mode_q);

  kiwi_tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .CLK_50 (CLK_50),
    .RST    (RST),
    .en     (~PAUSE),
    .clr    (mode_chg),
    .tick   (step)
  );

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      mode_q    <= MODE_OFF;
      pat       <= PAT_INIT_OFF;
      dir       <= DIR_UP;
      STEP_TICK <= 1'b0;
    end else if (mode_chg) begin
      mode_q    <= MODE;
      pat       <= init_pat(MODE);
      dir       <= DIR_UP;
      STEP_TICK <= 1'b0;
    end else if (step) begin
      STEP_TICK <= 1'b1;
      case (mode_q)
        MODE_BLINK: pat <= ~pat;
        MODE_CHASE: pat <= {pat[6:0], pat[7]};
        MODE_BOUNCE: begin
          // Reverse at the end LED so neither end is shown twice in a row.
          if (dir == DIR_UP) begin
            if (pat == 8'h80) begin
              pat <= 8'h40;
              dir <= DIR_DOWN;
            end else begin
              pat <= {pat[6:0], 1'b0};
            end
          end else begin
            if (pat == 8'h01) begin
              pat <= 8'h02;
              dir <= DIR_UP;
            end else begin
              pat <= {1'b0, pat[7:1]};
            end
          end
        end
        default: pat <= PAT_INIT_OFF;
      endcase
    end else begin
      STEP_TICK <= 1'b0;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge CLK_50) begin
    if (RST) pwm_cnt <= 8'd0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = (pwm_cnt < BRIGHT);
`else
  logic unused_bright;
  assign unused_bright = ^BRIGHT;
  assign pwm_on        = 1'b1;
`endif

  assign LED = ~(pat & {8{pwm_on}});

endmodule
